ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-client round-robin arbiter sharing one 64x8 single_port_ram (registered read).
// Optional macro RAM_ARB_LOCK_EN adds lock0/lock1 so one client can own the RAM port.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
`ifdef RAM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_out
);

  logic last;  // client granted most recently: 0 or 1
  logic elig0, elig1;
  logic win0, win1;

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_0,
    OWN_1
  } own_e;

  own_e own, own_next;

  always_ff @(posedge clk) begin
    if (rst) own <= OWN_NONE;
    else     own <= own_next;
  end

  // Ownership is taken by a locked grant and released by an unlocked grant
  // or by the owner leaving req low in a cycle where it could have been granted.
  always_comb begin
    // NOTE: default first so every path assigns own_next and no latch is inferred.
    own_next = own;
    unique case (own)
      OWN_NONE: begin
        if (win0 && lock0)      own_next = OWN_0;
        else if (win1 && lock1) own_next = OWN_1;
      end
      OWN_0: begin
        if ((win0 && !lock0) || (!req0 && !gnt0)) own_next = OWN_NONE;
      end
      OWN_1: begin
        if ((win1 && !lock1) || (!req1 && !gnt1)) own_next = OWN_NONE;
      end
      default: own_next = OWN_NONE;
    endcase
  end

  assign elig0 = req0 && !gnt0 && (own != OWN_1);
  assign elig1 = req1 && !gnt1 && (own != OWN_0);
`else
  // A client is never eligible in its own grant cycle: that is its handshake bubble.
  assign elig0 = req0 && !gnt0;
  assign elig1 = req1 && !gnt1;
`endif

  // On a tie the client not granted last wins.
  assign win0 = elig0 && (!elig1 || last);
  assign win1 = elig1 && (!elig0 || !last);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      last     <= 1'b1;
    end else begin
      gnt0    <= win0;
      gnt1    <= win1;
      // ram_we during the grant cycle tells whether that access was a read.
      rvalid0 <= gnt0 && !ram_we;
      rvalid1 <= gnt1 && !ram_we;
      if (win0) begin
        ram_addr <= addr0;
        ram_data <= wdata0;
        ram_we   <= we0;
        last     <= 1'b0;
      end else if (win1) begin
        ram_addr <= addr1;
        ram_data <= wdata1;
        ram_we   <= we1;
        last     <= 1'b1;
      end else begin
        ram_we   <= 1'b0;
      end
    end
  end

  assign rdata0 = ram_out;
  assign rdata1 = ram_out;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 64x8 registered-read RAM.
// Expected grants and read returns are queued by the stimulus and popped by a monitor.
module tb_ram_port_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic              req   [2];
  logic              we    [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
`ifdef RAM_ARB_LOCK_EN
  logic              lock  [2];
`endif
  logic              gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DATA_W-1:0] rdata0, rdata1, ram_data, ram_out;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] mem [64];

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  typedef struct {
    int              cyc;
    int              cl;
    logic            we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef RAM_ARB_LOCK_EN
    .lock0(lock[0]), .lock1(lock[1]),
`endif
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single_port_ram: synchronous write, registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_out <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_g(input int c, input int cl, input logic w,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.cyc = c; e.cl = cl; e.we = w; e.addr = a; e.data = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int c, input int cl, input logic [DATA_W-1:0] d);
    exp_t e;
    e.cyc = c; e.cl = cl; e.we = 1'b0; e.addr = '0; e.data = d;
    rq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request and hold it until the grant is seen; returns in the grant cycle.
  task automatic issue(input int cl, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit keep);
    bit got;
    got = 1'b0;
    we[cl] = w; addr[cl] = a; wdata[cl] = d; req[cl] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      got = (cl == 0) ? gnt0 : gnt1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL grant_timeout: client %0d got no grant in 20 cycles, expected a grant", cl);
    end
    if (!keep || !got) req[cl] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
      check("gnt_mutex", {63'd0, gnt0 & gnt1}, 64'd0);
      if (gq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_gnt: gnt0=%b gnt1=%b at cycle %0d, expected no grant", gnt0, gnt1, cyc);
      end else begin
        e = gq.pop_front();
        check("gnt_cycle", 64'(cyc), 64'(e.cyc));
        check("gnt_client", {63'd0, gnt1}, 64'(e.cl));
        check("ram_we", {63'd0, ram_we}, {63'd0, e.we});
        check("ram_addr", 64'(ram_addr), 64'(e.addr));
        check("ram_data", 64'(ram_data), 64'(e.data));
      end
    end
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      check("rvalid_mutex", {63'd0, rvalid0 & rvalid1}, 64'd0);
      if (rq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b at cycle %0d, expected none", rvalid0, rvalid1, cyc);
      end else begin
        e = rq.pop_front();
        check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        check("rvalid_client", {63'd0, rvalid1}, 64'(e.cl));
        check("rdata", 64'(rvalid1 ? rdata1 : rdata0), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
`ifdef RAM_ARB_LOCK_EN
      lock[i] = 1'b0;
`endif
    end

    // Reset held with both clients requesting: everything stays quiet.
    rst = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'd3; wdata[0] = 8'h5C;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 6'd4; wdata[1] = 8'h6D;
    repeat (2) begin
      @(negedge clk);
      check("rst_outputs", 64'({gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr, ram_data}), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = cyc;
    push_g(t + 1, 0, 1'b1, 6'd3, 8'h5C);
    push_g(t + 2, 1, 1'b1, 6'd4, 8'h6D);
    fork
      issue(0, 1'b1, 6'd3, 8'h5C, 1'b0);
      issue(1, 1'b1, 6'd4, 8'h6D, 1'b0);
    join

    // Single write from client 0, no rvalid.
    t = cyc;
    push_g(t + 1, 0, 1'b1, 6'd1, 8'hA1);
    issue(0, 1'b1, 6'd1, 8'hA1, 1'b0);

    // Client 1 reads it back.
    t = cyc;
    push_g(t + 1, 1, 1'b0, 6'd1, 8'h00);
    push_r(t + 2, 1, 8'hA1);
    issue(1, 1'b0, 6'd1, 8'h00, 1'b0);
    step(3);

    // Contention: alternate grants, cross reads, write right after a read.
    t = cyc;
    push_g(t + 1, 0, 1'b1, 6'd50, 8'hDF);
    push_g(t + 2, 1, 1'b1, 6'd51, 8'hEE);
    push_g(t + 3, 0, 1'b0, 6'd51, 8'h00);
    push_g(t + 4, 1, 1'b0, 6'd50, 8'h00);
    push_g(t + 5, 0, 1'b1, 6'd52, 8'h33);
    push_r(t + 4, 0, 8'hEE);
    push_r(t + 5, 1, 8'hDF);
    fork
      begin
        issue(0, 1'b1, 6'd50, 8'hDF, 1'b1);
        issue(0, 1'b0, 6'd51, 8'h00, 1'b1);
        issue(0, 1'b1, 6'd52, 8'h33, 1'b0);
      end
      begin
        issue(1, 1'b1, 6'd51, 8'hEE, 1'b1);
        issue(1, 1'b0, 6'd50, 8'h00, 1'b0);
      end
    join
    step(3);

    // Reset in the grant cycle of a read: no rvalid, pointer back to favour client 0.
    t = cyc;
    push_g(t + 1, 0, 1'b0, 6'd2, 8'h00);
    issue(0, 1'b0, 6'd2, 8'h00, 1'b0);
    rst = 1'b1;
    step(1);
    check("rst_mid_read", 64'({gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr, ram_data}), 64'd0);
    rst = 1'b0;
    t = cyc;
    push_g(t + 1, 0, 1'b1, 6'd5, 8'h11);
    push_g(t + 2, 1, 1'b1, 6'd6, 8'h22);
    fork
      issue(0, 1'b1, 6'd5, 8'h11, 1'b0);
      issue(1, 1'b1, 6'd6, 8'h22, 1'b0);
    join
    step(1);
    t = cyc;
    push_g(t + 1, 0, 1'b0, 6'd6, 8'h00);
    push_r(t + 2, 0, 8'h22);
    issue(0, 1'b0, 6'd6, 8'h00, 1'b0);
    step(3);

`ifdef RAM_ARB_LOCK_EN
    // Client 0 owns the port; client 1 waits until the unlocked grant releases it.
    t = cyc;
    push_g(t + 1, 0, 1'b1, 6'd10, 8'hA0);
    push_g(t + 3, 0, 1'b1, 6'd10, 8'hA1);
    push_g(t + 5, 0, 1'b1, 6'd10, 8'hA2);
    push_g(t + 7, 0, 1'b1, 6'd10, 8'hA3);
    push_g(t + 8, 1, 1'b1, 6'd11, 8'h77);
    fork
      begin
        lock[0] = 1'b1;
        issue(0, 1'b1, 6'd10, 8'hA0, 1'b1);
        issue(0, 1'b1, 6'd10, 8'hA1, 1'b1);
        issue(0, 1'b1, 6'd10, 8'hA2, 1'b1);
        lock[0] = 1'b0;
        issue(0, 1'b1, 6'd10, 8'hA3, 1'b0);
      end
      begin
        step(1);
        issue(1, 1'b1, 6'd11, 8'h77, 1'b0);
      end
    join
    step(3);
`endif

    step(2);
    check("grant_queue_drained", 64'(gq.size()), 64'd0);
    check("read_queue_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
